arcsin_cordic: RTL and testbench

- Parametrised, handshaked successor to the free-running fixed-point arcsin block.
- Computes arcsin(x), or arccos(x), of a signed fixed-point input as atan2(x, sqrt(1 - x^2)).
- Datapath: sequential square-root stage followed by iterative CORDIC vectoring.
- Sits in the basic math library.
- Feeds angle consumers through a valid/ready interface, with an out-of-domain error flag.

---
 rtl/arcsin_pkg.sv | 49 ++++
 rtl/isqrt_seq.sv | 55 +++++
 rtl/arcsin_cordic.sv | 159 +++++++++++++++
 tb/tb_arcsin_cordic.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arcsin_pkg.sv
// Shared types and constant generators for the arcsin/arccos CORDIC block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package arcsin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQUARE,
        ST_SQRT,
        ST_CORDIC,
        ST_FINISH,
        ST_HOLD
    } state_t;

    function automatic longint one_q(input int fw);
        return longint'(1) << fw;
    endfunction

    function automatic longint pi_2_q(input int fw);
        real s;
        s = 1.0;
        for (int k = 0; k < fw; k++) s = s * 2.0;
        return longint'(1.5707963267948966 * s);
    endfunction

    // atan(2^-i) scaled by 2^fw; Taylor series converges fast since 2^-i <= 0.5 for i >= 1.
    function automatic longint atan_q(input int i, input int fw);
        real t, term, acc, s;
        acc = 0.7853981633974483;
        if (i > 0) begin
            t = 1.0;
            for (int k = 0; k < i; k++) t = t / 2.0;
            acc  = 0.0;
            term = t;
            for (int n = 0; n < 40; n++) begin
                acc  = acc + (((n % 2) == 0) ? term : -term) / real'(2 * n + 1);
                term = term * t * t;
            end
        end
        s = 1.0;
        for (int k = 0; k < fw; k++) s = s * 2.0;
        return longint'(acc * s);
    endfunction

    localparam int     FRAC_W_DEF = 16;
    localparam longint ONE        = one_q(FRAC_W_DEF);
    localparam longint PI_2       = pi_2_q(FRAC_W_DEF);

endpackage

// File: rtl/isqrt_seq.sv
// Restoring digit-by-digit integer square root, one root bit per cycle.
// Latency: RW cycles after start; done is high during the final step.
// Backpressure: none; start is only honoured, the caller must wait for done.
module isqrt_seq #(
    parameter int RW = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2*RW-1:0] radicand,
    output logic            busy,
    output logic            done,
    output logic [RW-1:0]   root
);
    localparam int CW = $clog2(RW);

    logic [2*RW-1:0] rad_q;
    logic [RW+1:0]   rem_q;
    logic [RW+1:0]   rem_sh;
    logic [RW+1:0]   trial;
    logic [CW-1:0]   cnt;

    // Remainder stays below 2^RW between steps, so dropping its top bits is lossless.
    assign rem_sh = (RW+2)'({rem_q, rad_q[2*RW-1 -: 2]});
    assign trial  = {root, 2'b01};
    assign done   = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            rad_q <= '0;
            rem_q <= '0;
            root  <= '0;
            cnt   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            rad_q <= radicand;
            rem_q <= '0;
            root  <= '0;
            cnt   <= CW'(RW - 1);
        end else if (busy) begin
            rad_q <= rad_q << 2;
            if (rem_sh >= trial) begin
                rem_q <= rem_sh - trial;
                root  <= {root[RW-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh;
                root  <= {root[RW-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/arcsin_cordic.sv
// arcsin/arccos of a signed fixed-point operand as atan2(x, sqrt(1-x^2)) via CORDIC vectoring.
// Latency: FRAC_W+ITER+3 cycles accept-to-out_valid; out-of-domain operands finish 1 cycle after accept.
// Backpressure: one operation in flight; result held until out_ready, in_ready only in IDLE.
module arcsin_cordic
    import arcsin_pkg::*;
#(
    parameter int W      = 32,
    parameter int FRAC_W = 16,
    parameter int ITER   = 16,
    parameter int GUARD  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] value_sin,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] xita,
    output logic         err
);
    localparam int RW = FRAC_W + 1;
    localparam int DW = FRAC_W + GUARD + 3;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic signed [W-1:0]  ONE_W   = W'(one_q(FRAC_W));
    localparam logic [RW-1:0]        ONE_R   = RW'(one_q(FRAC_W));
    localparam logic signed [DW-1:0] HALF_PI = DW'(pi_2_q(FRAC_W));
    localparam logic signed [DW-1:0] RND     = DW'(longint'(1) << (GUARD - 1));

    state_t state, state_nxt;
    logic rdy_en, in_fire, oor;
    logic x_neg, mode_q, err_q;
    logic [RW-1:0] abs_in, abs_x, r_val, root;
    logic [2*RW-1:0] sq, radicand;
    logic sqrt_start, sqrt_busy, sqrt_done;
    logic signed [DW-1:0] xr, yr, zr, x_cur, y_cur, z_cur, x_sh, y_sh, x_nxt, y_nxt, z_nxt;
    logic signed [DW-1:0] z_rnd, a_val;
    logic signed [W-1:0] xita_nxt;
    logic [IW-1:0] iter;
    logic signed [DW-1:0] atan_tab [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic signed [DW-1:0] A = DW'(atan_q(g, FRAC_W + GUARD));
        assign atan_tab[g] = A;
    end

    // Range test on the signed operand, so the most-negative word never needs an absolute value.
    assign oor     = ($signed(value_sin) > ONE_W) || ($signed(value_sin) < -ONE_W);
    assign abs_in  = RW'(value_sin[W-1] ? (W'(0) - value_sin) : value_sin);
    assign in_fire = in_valid && in_ready;

    assign sq       = abs_x * abs_x;
    assign r_val    = ONE_R - RW'(sq >> FRAC_W);
    assign radicand = {1'b0, r_val, {FRAC_W{1'b0}}};

    isqrt_seq #(.RW(RW)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sqrt_start),
        .radicand (radicand),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (root)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (in_fire) state_nxt = oor ? ST_FINISH : ST_SQUARE;
            ST_SQUARE: state_nxt = ST_SQRT;
            ST_SQRT:   if (sqrt_done) state_nxt = ST_CORDIC;
            ST_CORDIC: if (iter == IW'(ITER - 1)) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_HOLD;
            ST_HOLD:   if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = rdy_en && (state == ST_IDLE);
        sqrt_start = (state == ST_SQUARE) && !sqrt_busy;
    end

    // First CORDIC step seeds from the fresh root and |x| instead of the registers.
    always_comb begin
        x_cur = xr;
        y_cur = yr;
        z_cur = zr;
        if (iter == '0) begin
            x_cur = DW'(root) <<< GUARD;
            y_cur = DW'(abs_x) <<< GUARD;
            z_cur = '0;
        end
        x_sh = x_cur >>> iter;
        y_sh = y_cur >>> iter;
        if (!y_cur[DW-1]) begin
            x_nxt = x_cur + y_sh;
            y_nxt = y_cur - x_sh;
            z_nxt = z_cur + atan_tab[iter];
        end else begin
            x_nxt = x_cur - y_sh;
            y_nxt = y_cur + x_sh;
            z_nxt = z_cur - atan_tab[iter];
        end
    end

    always_comb begin
        z_rnd    = (zr + RND) >>> GUARD;
        a_val    = err_q ? HALF_PI : (x_neg ? -z_rnd : z_rnd);
        xita_nxt = mode_q ? W'(HALF_PI - a_val) : W'(a_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            x_neg     <= 1'b0;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            abs_x     <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            iter      <= '0;
            out_valid <= 1'b0;
            xita      <= '0;
            err       <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (in_fire) begin
                x_neg  <= value_sin[W-1];
                mode_q <= mode;
                err_q  <= oor;
                abs_x  <= oor ? '0 : abs_in;
            end
            if (state == ST_CORDIC) begin
                xr   <= x_nxt;
                yr   <= y_nxt;
                zr   <= z_nxt;
                iter <= iter + 1'b1;
            end else begin
                iter <= '0;
            end
            if (state == ST_FINISH) begin
                out_valid <= 1'b1;
                xita      <= xita_nxt;
                err       <= err_q;
            end else if ((state == ST_HOLD) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arcsin_cordic.sv
// Bench for arcsin_cordic: directed spec points plus random operands against a real-math model.
module tb_arcsin_cordic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value_sin;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic signed [31:0] xita;
    logic        err;

    always #5 clk = ~clk;

    arcsin_cordic #(.W(32), .FRAC_W(16), .ITER(16), .GUARD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value_sin (value_sin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xita      (xita),
        .err       (err)
    );

    typedef struct {
        int    exp;
        int    tol;
        bit    er;
        bit    chk_x;
        string name;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    localparam int HALF = 102944;
    localparam int LAT  = 35;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic longint absdiff(input longint a, input longint b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Ideal result from real math; tolerance widens near |x|=1 where sqrt(1-x^2) quantises coarsely.
    function automatic void model(input int x, input bit m, output int e, output int tol, output bit er);
        real r;
        er  = (x > 65536) || (x < -65536);
        tol = (x <= 55705 && x >= -55705) ? 4 : 16;
        if (er) begin
            e = m ? 0 : HALF;
        end else begin
            r = real'(x) / 65536.0;
            e = m ? int'($acos(r) * 65536.0) : int'($asin(r) * 65536.0);
        end
    endfunction

    always @(posedge clk)
        if (rst_n && out_valid && out_ready && q.size() > 0) void'(q.pop_front());

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check(1'b0, "spurious_out_valid", 1, 0);
            end else begin
                cur = q[0];
                check(err == cur.er, {cur.name, "_err"}, err, cur.er);
                if (cur.chk_x)
                    check(absdiff(xita, cur.exp) <= cur.tol, cur.name, xita, cur.exp);
                check(!in_ready, {cur.name, "_in_ready_low"}, in_ready, 0);
            end
        end
    end

    task automatic issue(input int x, input bit m, input int e, input int tol, input bit er,
                         input bit chk_x, input string name, input bit rnd_bp, output int acc);
        int   n;
        exp_t ent;
        n = 0;
        while (!in_ready && n < 400) begin
            if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        acc = -1;
        if (!in_ready) begin
            check(1'b0, {name, "_in_ready_timeout"}, 0, 1);
            return;
        end
        ent.exp = e; ent.tol = tol; ent.er = er; ent.chk_x = chk_x; ent.name = name;
        q.push_back(ent);
        value_sin = x;
        mode      = m;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        acc       = cyc;
        in_valid  = 1'b0;
        value_sin = $urandom();
    endtask

    task automatic wait_valid(output int vc);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        vc = out_valid ? cyc : -1;
        if (!out_valid) check(1'b0, "out_valid_timeout", 0, 1);
    endtask

    task automatic op(input int x, input bit m, input int e, input int tol, input bit er,
                      input bit chk_x, input string name, input bit chk_lat);
        int acc, vc;
        issue(x, m, e, tol, er, chk_x, name, 1'b0, acc);
        wait_valid(vc);
        if (chk_lat) check(vc - acc == LAT, {name, "_latency"}, vc - acc, LAT);
        @(posedge clk); #1;
    endtask

    int sw_x [6] = '{0, 32'h8000, 46340, 56755, 32'h10000, -32'h8000};
    int sw_e [6] = '{0, 34315, 51470, 68629, 102944, -34315};
    int sw_t [6] = '{4, 4, 4, 4, 16, 4};
    int ac_x [3] = '{32'h8000, 0, -32'h10000};
    int ac_e [3] = '{68629, 102944, 205887};
    int ac_t [3] = '{4, 4, 16};
    int sp   [5] = '{65537, -65537, 32'h8000_0000, 65536, -65536};

    initial begin
        int acc, vc, bad, held, e, tol, x, sel;
        bit er, m;

        in_valid  = 1'b0;
        value_sin = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        model(32768, 1'b0, e, tol, er);
        check(absdiff(e, 34315) <= 1, "model_asin_half", e, 34315);
        model(0, 1'b1, e, tol, er);
        check(e == 102944, "model_acos_zero", e, 102944);
        model(-65536, 1'b1, e, tol, er);
        check(e == 205887, "model_acos_neg_one", e, 205887);
        model(98304, 1'b0, e, tol, er);
        check(er && e == HALF, "model_out_of_domain", e, HALF);

        repeat (3) @(negedge clk);
        check(!in_ready, "reset_in_ready", in_ready, 0);
        check(!out_valid, "reset_out_valid", out_valid, 0);
        check(xita == 0, "reset_xita", xita, 0);
        check(!err, "reset_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check(in_ready, "release_in_ready", in_ready, 1);

        issue(32'h8000, 1'b0, 34315, 4, 1'b0, 1'b1, "aborted", 1'b0, acc);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1 check(!in_ready, "midreset_in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check(in_ready, "midreset_release_in_ready", in_ready, 1);
        bad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check(bad == 0, "midreset_no_output", bad, 0);
        check(xita == 0, "midreset_xita", xita, 0);
        check(!err, "midreset_err", err, 0);

        for (int i = 0; i < 6; i++) op(sw_x[i], 1'b0, sw_e[i], sw_t[i], 1'b0, 1'b1, "asin_sweep", 1'b1);
        for (int i = 0; i < 3; i++) op(ac_x[i], 1'b1, ac_e[i], ac_t[i], 1'b0, 1'b1, "acos_sweep", 1'b1);

        op(32'h18000, 1'b0, HALF, 0, 1'b1, 1'b1, "domain_over", 1'b0);
        op(32'h8000_0000, 1'b0, 0, 0, 1'b1, 1'b0, "domain_min", 1'b0);
        op(32'h8000, 1'b0, 34315, 4, 1'b0, 1'b1, "domain_recover", 1'b1);

        out_ready = 1'b0;
        issue(32'h8000, 1'b1, 68629, 4, 1'b0, 1'b1, "bp_acos", 1'b0, acc);
        wait_valid(vc);
        held      = xita;
        value_sin = 32'h4000;
        mode      = 1'b0;
        in_valid  = 1'b1;
        bad       = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (!out_valid || xita !== held || in_ready) bad++;
        end
        check(bad == 0, "bp_hold_stable", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check(!out_valid, "bp_handshake", out_valid, 0);
        check(in_ready, "bp_in_ready_after", in_ready, 1);
        check(q.size() == 0, "bp_single_result", q.size(), 0);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check(bad == 0, "bp_second_ignored", bad, 0);

        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      x = int'($urandom_range(0, 131072)) - 65536;
            else if (sel <= 7) x = ($urandom_range(0, 1) != 0) ? -int'($urandom_range(55000, 65536))
                                                               : int'($urandom_range(55000, 65536));
            else if (sel == 8) x = $urandom();
            else               x = sp[$urandom_range(0, 4)];
            m = 1'(($urandom_range(0, 1)));
            model(x, m, e, tol, er);
            issue(x, m, e, tol, er, !er || !m, "random", 1'b1, acc);
        end
        out_ready = 1'b1;
        bad = 0;
        while (q.size() > 0 && bad < 500) begin
            @(posedge clk); #1;
            bad++;
        end
        check(q.size() == 0, "random_drain", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
